// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I/M-style integer execute unit.
// Single-cycle ops register their result on the accepting edge. MUL runs an
// XLEN-cycle shift-add. DIV/DIVU/REM/REMU run an XLEN-cycle restoring divide
// on operand magnitudes, and the signs are fixed up when the result is written.
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            Clock,
    input  logic            ResetN,
    input  logic            Start,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [1:0]      ALUOp,
    input  logic [XLEN-1:0] OpA,
    input  logic [XLEN-1:0] OpB,
    output logic [3:0]      ALUCtrl,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            Illegal,
    output logic            Busy,
    output logic            Done
);

    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [3:0] {
        CTRL_AND     = 4'b0000,
        CTRL_OR      = 4'b0001,
        CTRL_ADD     = 4'b0010,
        CTRL_XOR     = 4'b0011,
        CTRL_SLL     = 4'b0100,
        CTRL_SRL     = 4'b0101,
        CTRL_SUB     = 4'b0110,
        CTRL_SRA     = 4'b0111,
        CTRL_SLT     = 4'b1000,
        CTRL_SLTU    = 4'b1001,
        CTRL_MUL     = 4'b1010,
        CTRL_ILLEGAL = 4'b1011,
        CTRL_DIV     = 4'b1100,
        CTRL_DIVU    = 4'b1101,
        CTRL_REM     = 4'b1110,
        CTRL_REMU    = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        FINISH  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    alu_ctrl_e ctrl;

    // Map ALUOp/Funct7/Funct3 to an ALU control code. Anything unlisted is illegal.
    always_comb begin
        // NOTE: give every combinational output a default first. Then no path
        // leaves it unassigned, and no latch is inferred.
        ctrl = CTRL_ILLEGAL;
        case (ALUOp)
            2'b00: ctrl = CTRL_ADD;
            2'b01: ctrl = CTRL_SUB;
            2'b10: begin
                if (Funct7 == 7'b0000000) begin
                    case (Funct3)
                        3'b000:  ctrl = CTRL_ADD;
                        3'b001:  ctrl = CTRL_SLL;
                        3'b010:  ctrl = CTRL_SLT;
                        3'b011:  ctrl = CTRL_SLTU;
                        3'b100:  ctrl = CTRL_XOR;
                        3'b101:  ctrl = CTRL_SRL;
                        3'b110:  ctrl = CTRL_OR;
                        default: ctrl = CTRL_AND;
                    endcase
                end else if (Funct7 == 7'b0100000) begin
                    if (Funct3 == 3'b000) begin
                        ctrl = CTRL_SUB;
                    end else if (Funct3 == 3'b101) begin
                        ctrl = CTRL_SRA;
                    end
                end else if (ENABLE_M && (Funct7 == 7'b0000001)) begin
                    case (Funct3)
                        3'b000:  ctrl = CTRL_MUL;
                        3'b100:  ctrl = CTRL_DIV;
                        3'b101:  ctrl = CTRL_DIVU;
                        3'b110:  ctrl = CTRL_REM;
                        3'b111:  ctrl = CTRL_REMU;
                        default: ctrl = CTRL_ILLEGAL;
                    endcase
                end
            end
            default: begin
                // I-type: funct7 only qualifies the shifts.
                case (Funct3)
                    3'b000: ctrl = CTRL_ADD;
                    3'b010: ctrl = CTRL_SLT;
                    3'b011: ctrl = CTRL_SLTU;
                    3'b100: ctrl = CTRL_XOR;
                    3'b110: ctrl = CTRL_OR;
                    3'b111: ctrl = CTRL_AND;
                    3'b001: begin
                        if (Funct7 == 7'b0000000) begin
                            ctrl = CTRL_SLL;
                        end
                    end
                    default: begin
                        if (Funct7 == 7'b0000000) begin
                            ctrl = CTRL_SRL;
                        end else if (Funct7 == 7'b0100000) begin
                            ctrl = CTRL_SRA;
                        end
                    end
                endcase
            end
        endcase
    end

    assign ALUCtrl = ctrl;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;

    assign shamt = OpB[SHAMT_W-1:0];

    // Result of the single-cycle operations on the live operands.
    always_comb begin
        alu_res = '0;
        case (ctrl)
            CTRL_AND:  alu_res = OpA & OpB;
            CTRL_OR:   alu_res = OpA | OpB;
            CTRL_XOR:  alu_res = OpA ^ OpB;
            CTRL_ADD:  alu_res = OpA + OpB;
            CTRL_SUB:  alu_res = OpA - OpB;
            CTRL_SLL:  alu_res = OpA << shamt;
            CTRL_SRL:  alu_res = OpA >> shamt;
            CTRL_SRA:  alu_res = $unsigned($signed(OpA) >>> shamt);
            CTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(OpA) < $signed(OpB))};
            CTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, (OpA < OpB)};
            default:   alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand preparation for the iterative units
    // ------------------------------------------------------------------
    logic            signed_div;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign signed_div = (ctrl == CTRL_DIV) || (ctrl == CTRL_REM);
    assign a_neg      = signed_div && OpA[XLEN-1];
    assign b_neg      = signed_div && OpB[XLEN-1];
    assign mag_a      = a_neg ? (~OpA + 1'b1) : OpA;
    assign mag_b      = b_neg ? (~OpB + 1'b1) : OpB;

    // ------------------------------------------------------------------
    // State and working registers
    // ------------------------------------------------------------------
    // a_q: multiplicand (MUL) or dividend/quotient shift register (DIV)
    // b_q: multiplier (MUL) or divisor magnitude (DIV)
    // acc_q: partial product (MUL) or partial remainder (DIV)
    state_e             state_q,  state_d;
    logic [SHAMT_W-1:0] cnt_q,    cnt_d;
    logic [XLEN-1:0]    a_q,      a_d;
    logic [XLEN-1:0]    b_q,      b_d;
    logic [XLEN-1:0]    acc_q,    acc_d;
    alu_ctrl_e          op_q,     op_d;
    logic               neg_q,    neg_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q,   zero_d;
    logic               illegal_q, illegal_d;
    logic               done_q,   done_d;

    // ------------------------------------------------------------------
    // One iteration step of each algorithm, plus the final sign fix-up
    // ------------------------------------------------------------------
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;
    logic            sub_ok;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] prod_next;
    logic [XLEN-1:0] fin_res;
    logic            last_iter;

    // Restoring-divide and shift-add step values for the current registers.
    always_comb begin
        rem_shift = {acc_q, a_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        sub_ok    = (rem_shift >= {1'b0, b_q});
        rem_next  = sub_ok ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next  = {a_q[XLEN-2:0], sub_ok};
        prod_next = acc_q + (b_q[0] ? a_q : {XLEN{1'b0}});
    end

    // Final value written when the last iteration completes.
    // A zero divisor keeps the all-ones quotient unsigned, regardless of the
    // dividend sign.
    always_comb begin
        fin_res = prod_next;
        case (op_q)
            CTRL_DIV:  fin_res = (neg_q && (b_q != '0)) ? (~quo_next + 1'b1) : quo_next;
            CTRL_DIVU: fin_res = quo_next;
            CTRL_REM:  fin_res = neg_q ? (~rem_next + 1'b1) : rem_next;
            CTRL_REMU: fin_res = rem_next;
            default:   fin_res = prod_next;
        endcase
    end

    assign last_iter = (cnt_q == SHAMT_W'(XLEN - 1));

    // Next-state logic for the FSM, the working registers and the outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        op_d      = op_q;
        neg_d     = neg_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (ctrl)
                        CTRL_MUL: begin
                            state_d = MUL_RUN;
                            a_d     = OpA;
                            b_d     = OpB;
                            acc_d   = '0;
                            cnt_d   = '0;
                            op_d    = ctrl;
                            neg_d   = 1'b0;
                        end
                        CTRL_DIV, CTRL_DIVU, CTRL_REM, CTRL_REMU: begin
                            state_d = DIV_RUN;
                            a_d     = mag_a;
                            b_d     = mag_b;
                            acc_d   = '0;
                            cnt_d   = '0;
                            op_d    = ctrl;
                            // The quotient takes the XOR of the signs; the
                            // remainder takes the sign of the dividend.
                            neg_d   = (ctrl == CTRL_REM) ? a_neg : (a_neg ^ b_neg);
                        end
                        default: begin
                            result_d  = alu_res;
                            zero_d    = (alu_res == '0);
                            illegal_d = (ctrl == CTRL_ILLEGAL);
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (state_q == MUL_RUN) begin
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    acc_d = prod_next;
                end else begin
                    a_d   = quo_next;
                    acc_d = rem_next;
                end
                cnt_d = cnt_q + SHAMT_W'(1);
                if (last_iter) begin
                    // The result lands on the edge that enters FINISH, so it
                    // is visible for the whole FINISH cycle together with Done.
                    state_d   = FINISH;
                    result_d  = fin_res;
                    zero_d    = (fin_res == '0);
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            op_q      <= CTRL_ILLEGAL;
            neg_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values of the others, whatever the statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign Result  = result_q;
    assign Zero    = zero_q;
    assign Illegal = illegal_q;
    assign Done    = done_q;
    assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against
// an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] word_t;

    localparam logic [3:0] C_AND  = 4'b0000, C_OR   = 4'b0001, C_ADD  = 4'b0010, C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100, C_SRL  = 4'b0101, C_SUB  = 4'b0110, C_SRA  = 4'b0111;
    localparam logic [3:0] C_SLT  = 4'b1000, C_SLTU = 4'b1001, C_MUL  = 4'b1010, C_ILL  = 4'b1011;
    localparam logic [3:0] C_DIV  = 4'b1100, C_DIVU = 4'b1101, C_REM  = 4'b1110, C_REMU = 4'b1111;

    logic       Clock = 1'b0;
    logic       ResetN;
    logic       Start;
    logic       start_nm;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic [1:0] ALUOp;
    word_t      OpA, OpB;

    logic [3:0] ALUCtrl, ctrl_nm;
    word_t      Result, result_nm;
    logic       Zero, Illegal, Busy, Done;
    logic       zero_nm, illegal_nm, busy_nm, done_nm;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
        .Clock(Clock), .ResetN(ResetN), .Start(Start), .Funct7(Funct7), .Funct3(Funct3),
        .ALUOp(ALUOp), .OpA(OpA), .OpB(OpB), .ALUCtrl(ALUCtrl), .Result(Result),
        .Zero(Zero), .Illegal(Illegal), .Busy(Busy), .Done(Done)
    );

    alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nm (
        .Clock(Clock), .ResetN(ResetN), .Start(start_nm), .Funct7(Funct7), .Funct3(Funct3),
        .ALUOp(ALUOp), .OpA(OpA), .OpB(OpB), .ALUCtrl(ctrl_nm), .Result(result_nm),
        .Zero(zero_nm), .Illegal(illegal_nm), .Busy(busy_nm), .Done(done_nm)
    );

    always #5 Clock = ~Clock;

    // RISC-V funct3 meaning of the base integer ops, and of the M-extension ops.
    logic [3:0] base_ops [8] = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
    logic [3:0] m_ops    [8] = '{C_MUL, C_ILL, C_ILL, C_ILL, C_DIV, C_DIVU, C_REM, C_REMU};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_ctrl(input logic [6:0] f7, input logic [2:0] f3,
                                              input logic [1:0] op, input bit m_en);
        if (op == 2'b00) return C_ADD;
        if (op == 2'b01) return C_SUB;
        if (op == 2'b10) begin
            if (f7 == 7'h00) return base_ops[f3];
            if (f7 == 7'h20) return (f3 == 3'd0) ? C_SUB : ((f3 == 3'd5) ? C_SRA : C_ILL);
            if (f7 == 7'h01 && m_en) return m_ops[f3];
            return C_ILL;
        end
        if (f3 == 3'd1) return (f7 == 7'h00) ? C_SLL : C_ILL;
        if (f3 == 3'd5) return (f7 == 7'h00) ? C_SRL : ((f7 == 7'h20) ? C_SRA : C_ILL);
        return base_ops[f3];
    endfunction

    function automatic word_t model_result(input logic [3:0] c, input word_t a, input word_t b);
        int       sa;
        int       sb;
        logic [4:0] sh;
        logic     ovf;
        sa  = a;
        sb  = b;
        sh  = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            C_AND:  return a & b;
            C_OR:   return a | b;
            C_XOR:  return a ^ b;
            C_ADD:  return a + b;
            C_SUB:  return a - b;
            C_SLL:  return a << sh;
            C_SRL:  return a >> sh;
            C_SRA:  return word_t'(sa >>> sh);
            C_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            C_SLTU: return (a < b) ? 32'd1 : 32'd0;
            C_MUL:  return a * b;
            C_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : word_t'(sa / sb));
            C_REM:  return (b == 0) ? a : (ovf ? 32'd0 : word_t'(sa % sb));
            C_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            C_REMU: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_multi(input logic [3:0] c);
        return c inside {C_MUL, C_DIV, C_DIVU, C_REM, C_REMU};
    endfunction

    function automatic word_t pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return word_t'($urandom_range(0, 16));
            default: return word_t'($urandom);
        endcase
    endfunction

    // Issue one op from IDLE on the main DUT and compare everything it reports.
    task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [1:0] op, input word_t a, input word_t b);
        logic [3:0] ec;
        word_t      er;
        int         exp_lat;
        int         lat;
        ec      = model_ctrl(f7, f3, op, 1'b1);
        er      = model_result(ec, a, b);
        exp_lat = is_multi(ec) ? XLEN + 1 : 1;
        @(negedge Clock);
        Funct7 = f7; Funct3 = f3; ALUOp = op; OpA = a; OpB = b; Start = 1'b1;
        #1 check({tag, "/ctrl"}, ALUCtrl, ec);
        @(posedge Clock);
        #1 Start = 1'b0;
        lat = 0;
        for (int k = 1; k <= XLEN + 8; k++) begin
            @(negedge Clock);
            if (Done) begin
                lat = k;
                break;
            end
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/result"}, Result, er);
        check({tag, "/zero"}, Zero, (er == 0));
        check({tag, "/illegal"}, Illegal, (ec == C_ILL));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    busy_cnt;
        int    done_at;
        int    dones;
        word_t res_at_done;
        logic  post_done;
        logic  post_busy;
        word_t post_res;

        ResetN = 1'b0; Start = 1'b0; start_nm = 1'b0;
        Funct7 = '0; Funct3 = '0; ALUOp = '0; OpA = '0; OpB = '0;
        repeat (2) @(negedge Clock);
        check("reset/result", Result, 0);
        check("reset/zero", Zero, 1);
        check("reset/illegal", Illegal, 0);
        check("reset/busy", Busy, 0);
        check("reset/done", Done, 0);
        ResetN = 1'b1;

        // Directed single-cycle cases.
        run_op("sub_neg", 7'h20, 3'd0, 2'b10, 32'd5, 32'd7);
        run_op("branch_eq", 7'h01, 3'd4, 2'b01, 32'h1234, 32'h1234);
        run_op("itype_f7_ignored", 7'h7F, 3'd0, 2'b11, 32'd40, 32'd2);
        run_op("srai", 7'h20, 3'd5, 2'b11, 32'h8000_00F0, 32'd4);
        run_op("sll_shamt_mask", 7'h00, 3'd1, 2'b10, 32'h0000_0003, 32'hFFFF_FFE1);
        run_op("slt_neg", 7'h00, 3'd2, 2'b10, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu_neg", 7'h00, 3'd3, 2'b10, 32'hFFFF_FFFF, 32'd1);
        run_op("rtype_illegal", 7'h20, 3'd1, 2'b10, 32'd9, 32'd9);

        // MUL: busy span, done position, ignored Start mid-run and during FINISH.
        @(negedge Clock);
        Funct7 = 7'h01; Funct3 = 3'd0; ALUOp = 2'b10; OpA = 32'hFFFF_FFFF; OpB = 32'd3; Start = 1'b1;
        #1 check("mul/ctrl", ALUCtrl, C_MUL);
        @(posedge Clock);
        #1 Start = 1'b0;
        busy_cnt = 0; done_at = 0; res_at_done = '0;
        post_done = 1'b1; post_busy = 1'b1; post_res = '0;
        for (int k = 1; k <= XLEN + 8; k++) begin
            @(negedge Clock);
            if (Busy) busy_cnt++;
            if (k == 10) begin
                ALUOp = 2'b00; OpA = 32'd1; OpB = 32'd1; Start = 1'b1;
            end else if (k == 11) begin
                Start = 1'b0;
            end
            if (Done) begin
                done_at     = k;
                res_at_done = Result;
                ALUOp = 2'b00; OpA = 32'd2; OpB = 32'd2; Start = 1'b1;
                @(negedge Clock);
                post_done = Done;
                post_busy = Busy;
                post_res  = Result;
                Start = 1'b0;
                break;
            end
        end
        check("mul/busy_cycles", busy_cnt, XLEN + 1);
        check("mul/done_cycle", done_at, XLEN + 1);
        check("mul/result", res_at_done, 32'hFFFF_FFFD);
        check("mul/start_in_finish_done", post_done, 0);
        check("mul/start_in_finish_busy", post_busy, 0);
        check("mul/result_held", post_res, 32'hFFFF_FFFD);

        // Division corner cases.
        run_op("div_overflow", 7'h01, 3'd4, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_overflow", 7'h01, 3'd6, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_neg", 7'h01, 3'd6, 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("div_neg_by_zero", 7'h01, 3'd4, 2'b10, 32'hFFFF_FFFB, 32'd0);
        run_op("rem_neg_by_zero", 7'h01, 3'd6, 2'b10, 32'hFFFF_FFFB, 32'd0);
        run_op("div_mixed", 7'h01, 3'd4, 2'b10, 32'd100, 32'hFFFF_FFF9);
        run_op("divu_by_zero", 7'h01, 3'd5, 2'b10, 32'd1234, 32'd0);

        // M ops decode as illegal when the extension is disabled.
        @(negedge Clock);
        Funct7 = 7'h01; Funct3 = 3'd4; ALUOp = 2'b10; OpA = 32'd10; OpB = 32'd3; start_nm = 1'b1;
        #1 check("nom/ctrl", ctrl_nm, C_ILL);
        check("m/ctrl_div", ALUCtrl, C_DIV);
        @(posedge Clock);
        #1 start_nm = 1'b0;
        @(negedge Clock);
        check("nom/done", done_nm, 1);
        check("nom/illegal", illegal_nm, 1);
        check("nom/result", result_nm, 0);
        check("nom/zero", zero_nm, 1);
        check("nom/busy", busy_nm, 0);

        // Reset in the middle of a DIVU aborts it without a Done.
        @(negedge Clock);
        Funct7 = 7'h01; Funct3 = 3'd5; ALUOp = 2'b10; OpA = 32'd100; OpB = 32'd7; Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        repeat (5) @(negedge Clock);
        check("abort/busy_before", Busy, 1);
        #1 ResetN = 1'b0;
        #1;
        check("abort/busy", Busy, 0);
        check("abort/done", Done, 0);
        check("abort/result", Result, 0);
        check("abort/zero", Zero, 1);
        @(negedge Clock);
        ResetN = 1'b1;
        dones = 0;
        repeat (XLEN + 4) begin
            @(negedge Clock);
            if (Done || Busy) dones++;
        end
        check("abort/no_done", dones, 0);
        run_op("after_abort", 7'h01, 3'd5, 2'b10, 32'd100, 32'd7);

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [6:0] f7;
            logic [2:0] f3;
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            run_op($sformatf("rand%0d", i), f7, f3, op, pick_operand(), pick_operand());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter ENABLE_M, default 1; 1 enables the RV M-subset MUL/DIV/DIVU/REM/REMU, 0 decodes them as illegal.
REQ-003 Port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port ResetN, input, 1 bit, asynchronous active-low reset.
REQ-005 Port Start, input, 1 bit, requests an operation on the current Funct7/Funct3/ALUOp/OpA/OpB.
REQ-006 Port Funct7, input, 7 bits, instruction funct7 field.
REQ-007 Port Funct3, input, 3 bits, instruction funct3 field.
REQ-008 Port ALUOp, input, 2 bits: 00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-009 Port OpA, input, XLEN bits, first operand (rs1).
REQ-010 Port OpB, input, XLEN bits, second operand (rs2 or immediate).
REQ-011 Port ALUCtrl, output, 4 bits, the combinational decode of the current inputs.
REQ-012 Port Result, output, XLEN bits, the registered result of the last completed operation.
REQ-013 Port Zero, output, 1 bit, registered flag that is 1 when Result equals 0.
REQ-014 Port Illegal, output, 1 bit, registered flag that is 1 when the last accepted operation had no legal decode.
REQ-015 Port Busy, output, 1 bit, 1 while a multi-cycle operation is in progress.
REQ-016 Port Done, output, 1 bit, one-cycle pulse that marks Result, Zero and Illegal as updated.

Function
REQ-017 ALUCtrl encoding SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, MUL 1010, DIV 1100, DIVU 1101, REM 1110, REMU 1111; illegal SHALL decode as 1011.
REQ-018 ALUOp 00 SHALL decode ADD and ALUOp 01 SHALL decode SUB, both regardless of Funct7/Funct3.
REQ-019 ALUOp 10 SHALL decode the full RV32I R-type set from Funct7/Funct3 (0000000, 0100000 for SUB/SRA) plus Funct7 0000001 with Funct3 000/100/101/110/111 as MUL/DIV/DIVU/REM/REMU when ENABLE_M=1; any other combination is illegal.
REQ-020 ALUOp 11 SHALL decode the I-type set; Funct7 SHALL be ignored except for shifts (0000000 SLL/SRL, 0100000 SRA), and SUB and the M ops are not reachable from ALUOp 11.
REQ-021 The shift amount SHALL be OpB[log2(XLEN)-1:0]; SLT/SLTU SHALL produce the zero-extended value 1 or 0.
REQ-022 FSM states SHALL be IDLE, MUL_RUN, DIV_RUN and FINISH.
REQ-023 A Start in IDLE for a single-cycle op (including illegal) SHALL register the result at that edge, with Done=1 in the following cycle and the FSM remaining in IDLE.
REQ-024 A Start in IDLE for MUL SHALL enter MUL_RUN, which performs an iterative shift-add of exactly XLEN cycles, then FINISH.
REQ-025 A Start in IDLE for DIV, DIVU, REM or REMU SHALL enter DIV_RUN, which performs a restoring division of exactly XLEN cycles, then FINISH.
REQ-026 FINISH SHALL last one cycle, write Result/Zero, pulse Done and return to IDLE; Done SHALL follow the accepting edge by XLEN+1 cycles.
REQ-027 Busy SHALL be 1 in MUL_RUN, DIV_RUN and FINISH; Start while Busy=1 SHALL be ignored, and operands SHALL be captured at acceptance.
REQ-028 MUL SHALL produce the low XLEN bits of the product.
REQ-029 For DIV/REM, operands SHALL be converted to magnitude and the signs applied at FINISH; the remainder SHALL take the sign of the dividend.
REQ-030 Divide by zero SHALL give quotient all-ones and remainder = OpA, computed in the full XLEN cycles.
REQ-031 Signed overflow (most-negative / -1) SHALL give quotient = most-negative and remainder = 0.
REQ-032 A Start in the same cycle as FINISH SHALL be ignored; a new op SHALL be accepted from the next IDLE cycle.
REQ-033 Result, Zero and Illegal SHALL hold between Done pulses.

Reset
REQ-034 ResetN=0 SHALL immediately force IDLE, Result=0, Zero=1, Illegal=0, Busy=0, Done=0 and clear the iteration counter.
REQ-035 Reset during MUL_RUN or DIV_RUN SHALL abort the operation with no Done, and the first Start after release SHALL be accepted normally.

Verification
REQ-036 XLEN=32, ALUOp=10, Funct7=0100000, Funct3=000, OpA=5, OpB=7, Start -> next cycle Done=1, Result=0xFFFFFFFE, Zero=0.
REQ-037 ALUOp=01, OpA=OpB=0x1234, Start -> Result=0, Zero=1, ALUCtrl=0110.
REQ-038 MUL, OpA=0xFFFFFFFF, OpB=3, Start -> Busy for 33 cycles, Done at cycle 33, Result=0xFFFFFFFD; a second Start at cycle 10 is ignored.
REQ-039 DIV with OpA=0x80000000, OpB=0xFFFFFFFF -> Result=0x80000000; REM with OpA=-7, OpB=2 -> Result=0xFFFFFFFF; DIVU with OpB=0 -> Result=0xFFFFFFFF.
REQ-040 ALUOp=10, Funct7=0000001, ENABLE_M=0 -> ALUCtrl=1011, Illegal=1, Result=0; ResetN low at cycle 5 of a DIVU -> Busy=0 immediately and no Done.
